// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial ALU units (serial adder/subtractor).
// Holds the controller state encoding, default widths and the signed
// overflow rule for subtraction.
package serial_subtractor_pkg;

    // Controller states; the encoding is shared with the serial adder controller.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } sub_state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CW    = 3;

    // Signed overflow of A - B: the operand signs differ and the result sign
    // differs from the minuend sign.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                          input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor cell with its borrow flip-flop.
// Ports:
//   Clock  - clock, state updates on the falling edge
//   Resetn - asynchronous active-low reset of the borrow flop
//   Clear  - synchronous clear of the borrow flop (operand load)
//   x, y   - minuend / subtrahend bits for the current position
//   d      - difference bit (combinational)
//   br_n   - borrow into the next position (combinational)
module serial_subtractor_cell (
    input  logic Clock,
    input  logic Resetn,
    input  logic Clear,
    input  logic x,
    input  logic y,
    output logic d,
    output logic br_n
);

    logic br_r;

    // Difference and borrow-out from the current bits and the stored borrow.
    always_comb begin
        d    = x ^ y ^ br_r;
        br_n = (~x & y) | (~(x ^ y) & br_r);
    end

    // Borrow flop: cleared on reset or at operand load, otherwise tracks borrow-out.
    always_ff @(negedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            br_r <= 1'b0;
        end else if (Clear) begin
            br_r <= 1'b0;
        end else begin
            br_r <= br_n;
        end
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor D = A - B with Start/Busy/Done control.
// Operands are loaded in parallel, the difference is formed LSB-first over N
// falling edges and captured into D only when the last bit is produced.
// Ports:
//   Clock    - clock, all state updates on the falling edge
//   Resetn   - asynchronous active-low reset
//   Start    - launch request, honoured only in IDLE
//   A, B     - minuend / subtrahend, captured on the accepted Start edge
//   D        - difference, held from completion until the next accepted Start
//   Borrow   - unsigned borrow-out (A < B), valid with D
//   Overflow - signed overflow of A - B, valid with D
//   Busy     - high while an operation is in SHIFT or DONE
//   Done     - one-cycle completion pulse
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int N  = DEFAULT_WIDTH,
    parameter int CW = DEFAULT_CW
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         Start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] D,
    output logic         Borrow,
    output logic         Overflow,
    output logic         Busy,
    output logic         Done
);

    sub_state_t    state_r, state_next;
    logic [N-1:0]  ra_r, rb_r, d_r;
    logic [CW-1:0] cnt_r;
    logic          a_msb_r, b_msb_r;
    logic          borrow_r, ovf_r, busy_r, done_r;
    logic          load_s, last_s, d_s, br_n_s;

    serial_subtractor_cell u_cell (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Clear  (load_s),
        .x      (ra_r[0]),
        .y      (rb_r[0]),
        .d      (d_s),
        .br_n   (br_n_s)
    );

    // Next-state decode plus load / last-bit strobes.
    always_comb begin
        state_next = state_r;
        load_s     = 1'b0;
        last_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    load_s     = 1'b1;
                    state_next = ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CW'(N - 1)) begin
                    last_s     = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register; Busy/Done are registered from the next state so they are glitch-free.
    always_ff @(negedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next;
            busy_r  <= (state_next != ST_IDLE);
            done_r  <= (state_next == ST_DONE);
        end
    end

    // Operand shift registers and bit counter; the difference refills RA from the MSB.
    always_ff @(negedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ra_r    <= {N{1'b0}};
            rb_r    <= {N{1'b0}};
            cnt_r   <= {CW{1'b0}};
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
        end else if (load_s) begin
            ra_r    <= A;
            rb_r    <= B;
            cnt_r   <= {CW{1'b0}};
            a_msb_r <= A[N-1];
            b_msb_r <= B[N-1];
        end else if (state_r == ST_SHIFT) begin
            ra_r    <= {d_s, ra_r[N-1:1]};
            rb_r    <= {1'b0, rb_r[N-1:1]};
            cnt_r   <= cnt_r + CW'(1);
            a_msb_r <= a_msb_r;
            b_msb_r <= b_msb_r;
        end else begin
            ra_r    <= ra_r;
            rb_r    <= rb_r;
            cnt_r   <= cnt_r;
            a_msb_r <= a_msb_r;
            b_msb_r <= b_msb_r;
        end
    end

    // Result capture on the last shift edge only, so D never shows partial results.
    always_ff @(negedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            d_r      <= {N{1'b0}};
            borrow_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (last_s) begin
            d_r      <= {d_s, ra_r[N-1:1]};
            borrow_r <= br_n_s;
            ovf_r    <= sub_overflow(a_msb_r, b_msb_r, d_s);
        end else begin
            d_r      <= d_r;
            borrow_r <= borrow_r;
            ovf_r    <= ovf_r;
        end
    end

    assign D        = d_r;
    assign Borrow   = borrow_r;
    assign Overflow = ovf_r;
    assign Busy     = busy_r;
    assign Done     = done_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N=4). The DUT acts on falling
// edges; the bench drives inputs and samples outputs around rising edges.
module tb_serial_subtractor;

    localparam int N = 4;

    logic         Clock;
    logic         Resetn;
    logic         Start;
    logic [N-1:0] A, B, D;
    logic         Borrow, Overflow, Busy, Done;

    int total = 0;
    int bad   = 0;
    logic [N-1:0] exp_d = '0;

    serial_subtractor #(.N(N), .CW(3)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Start    (Start),
        .A        (A),
        .B        (B),
        .D        (D),
        .Borrow   (Borrow),
        .Overflow (Overflow),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference: plain arithmetic on the operands.
    function automatic logic [N-1:0] ref_diff(input logic [N-1:0] a, input logic [N-1:0] b);
        int v;
        v = (int'(a) - int'(b) + 16) % 16;
        return v[N-1:0];
    endfunction

    function automatic logic ref_borrow(input logic [N-1:0] a, input logic [N-1:0] b);
        return int'(a) < int'(b);
    endfunction

    function automatic logic ref_ovf(input logic [N-1:0] a, input logic [N-1:0] b);
        int sa, sb, sd;
        sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
        sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
        sd = sa - sb;
        return (sd < -8) || (sd > 7);
    endfunction

    // Launch one operation; must be called just after a rising edge.
    // Returns just after the rising edge following the return to IDLE.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold);
        logic [N-1:0] ed;
        logic eb, eo;
        ed = ref_diff(a, b);
        eb = ref_borrow(a, b);
        eo = ref_ovf(a, b);
        A = a; B = b; Start = 1'b1;
        @(negedge Clock);
        #1;
        if (!hold) Start = 1'b0;
        for (int k = 1; k <= N; k++) begin
            @(posedge Clock);
            total++;
            if (Busy !== 1'b1 || Done !== 1'b0 || D !== exp_d) begin
                bad++;
                $display("FAIL shift_phase a=%0d b=%0d k=%0d: busy=%b done=%b d=%b, want busy=1 done=0 d=%b",
                         a, b, k, Busy, Done, D, exp_d);
            end
            @(negedge Clock);
        end
        @(posedge Clock);
        total++;
        if (Done !== 1'b1 || Busy !== 1'b1) begin
            bad++;
            $display("FAIL done_pulse a=%0d b=%0d: done=%b busy=%b, want 1 1", a, b, Done, Busy);
        end
        total++;
        if (D !== ed) begin
            bad++;
            $display("FAIL diff a=%0d b=%0d: got %b, want %b", a, b, D, ed);
        end
        total++;
        if (Borrow !== eb) begin
            bad++;
            $display("FAIL borrow a=%0d b=%0d: got %b, want %b", a, b, Borrow, eb);
        end
        total++;
        if (Overflow !== eo) begin
            bad++;
            $display("FAIL overflow a=%0d b=%0d: got %b, want %b", a, b, Overflow, eo);
        end
        exp_d = ed;
        @(negedge Clock);
        @(posedge Clock);
        total++;
        if (Done !== 1'b0 || Busy !== 1'b0 || D !== ed) begin
            bad++;
            $display("FAIL after_done a=%0d b=%0d: done=%b busy=%b d=%b, want 0 0 %b",
                     a, b, Done, Busy, D, ed);
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0; Start = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge Clock);
        total++;
        if (D !== 4'b0000 || Borrow !== 1'b0 || Overflow !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: d=%b br=%b ov=%b busy=%b done=%b, want all 0",
                     D, Borrow, Overflow, Busy, Done);
        end
        Resetn = 1'b1;
        exp_d = '0;
    endtask

    task automatic test_plan_vectors();
        run_op(4'd5, 4'd2, 1'b0);
        run_op(4'd2, 4'd5, 1'b0);
        run_op(4'b1000, 4'b0001, 1'b0);
        run_op(4'b0111, 4'b1111, 1'b0);
    endtask

    // With Start low in IDLE the result registers must hold.
    task automatic test_idle_hold();
        for (int i = 0; i < 3; i++) begin
            A = 4'(i + 9); B = 4'(i);
            @(posedge Clock);
            total++;
            if (Busy !== 1'b0 || D !== exp_d) begin
                bad++;
                $display("FAIL idle_hold: busy=%b d=%b, want 0 %b", Busy, D, exp_d);
            end
        end
    endtask

    task automatic test_start_ignored();
        A = 4'd6; B = 4'd1; Start = 1'b1;
        @(negedge Clock);                  // edge 0: accepted
        #1 Start = 1'b0;
        @(posedge Clock);
        A = 4'd3; B = 4'd3; Start = 1'b1;  // request during SHIFT
        @(negedge Clock);                  // edge 1
        #1 Start = 1'b0;
        repeat (3) @(negedge Clock);       // edges 2..4
        @(posedge Clock);
        total++;
        if (D !== 4'b0101 || Done !== 1'b1) begin
            bad++;
            $display("FAIL start_ignored_shift: d=%b done=%b, want 0101 1", D, Done);
        end
        Start = 1'b1;                      // request during DONE
        @(negedge Clock);                  // edge 5: DONE -> IDLE
        #1 Start = 1'b0;
        exp_d = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            @(posedge Clock);
            total++;
            if (Busy !== 1'b0 || D !== 4'b0101) begin
                bad++;
                $display("FAIL start_ignored_done: busy=%b d=%b, want 0 0101", Busy, D);
            end
        end
        run_op(4'd3, 4'd3, 1'b0);
    endtask

    task automatic test_reset_abort();
        A = 4'd5; B = 4'd2; Start = 1'b1;
        @(negedge Clock);
        #1 Start = 1'b0;
        repeat (2) @(negedge Clock);
        #2 Resetn = 1'b0;
        #1;
        total++;
        if (D !== 4'b0000 || Borrow !== 1'b0 || Overflow !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort: d=%b br=%b ov=%b busy=%b done=%b, want all 0",
                     D, Borrow, Overflow, Busy, Done);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock);
            total++;
            if (Done !== 1'b0 || Busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_no_done: done=%b busy=%b, want 0 0", Done, Busy);
            end
        end
        Resetn = 1'b1;
        exp_d = '0;
        run_op(4'd7, 4'd7, 1'b0);
    endtask

    // Start held high: each new operation begins on the first IDLE edge.
    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
        end
        Start = 1'b0;
        @(negedge Clock);
        @(posedge Clock);
        Start = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(posedge Clock);
        end
    endtask

    initial begin
        test_reset();
        @(posedge Clock);
        test_plan_vectors();
        test_idle_hold();
        test_start_ignored();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
